// File: rtl/fdtd_step_sched_if.sv
// Handshake bundle between the FDTD step scheduler and its host/accelerator side.
// The scheduler uses the master view; the surrounding logic (or a bench) uses slave.
interface fdtd_step_sched_if #(
    parameter int STEP_CNT_WIDTH = 16
);
    logic                      start;
    logic                      abort;
    logic [STEP_CNT_WIDTH-1:0] num_steps;
    logic                      buffer_done;
    logic                      wrt_hy_start;
    logic                      wrt_ez_start;
    logic                      wrt_src_start;
    logic                      mem_rd_end;

    logic                      buffer_hy_start;
    logic                      buffer_ez_start;
    logic                      calc_hy_flg;
    logic                      calc_ez_flg;
    logic                      calc_src_flg;
    logic                      busy;
    logic                      done;
    logic                      timeout;
    logic [STEP_CNT_WIDTH-1:0] step_cnt;
    logic [3:0]                state;

    modport master (
        input  start, abort, num_steps, buffer_done, wrt_hy_start, wrt_ez_start,
               wrt_src_start, mem_rd_end,
        output buffer_hy_start, buffer_ez_start, calc_hy_flg, calc_ez_flg, calc_src_flg,
               busy, done, timeout, step_cnt, state
    );

    modport slave (
        output start, abort, num_steps, buffer_done, wrt_hy_start, wrt_ez_start,
               wrt_src_start, mem_rd_end,
        input  buffer_hy_start, buffer_ez_start, calc_hy_flg, calc_ez_flg, calc_src_flg,
               busy, done, timeout, step_cnt, state
    );
endinterface

// File: rtl/fdtd_step_sched.sv
// FDTD time-step scheduler: walks load/update/write-back phases per step, counts
// steps up to a latched limit, with a per-phase watchdog and abort.
module fdtd_step_sched #(
    parameter int TIME_STEPS     = 50,
    parameter int STEP_CNT_WIDTH = 16,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fdtd_step_sched_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LD_HY    = 4'd1,
        S_LD_EZ    = 4'd2,
        S_CALC_HY  = 4'd3,
        S_WB_HY    = 4'd4,
        S_CALC_EZ  = 4'd5,
        S_CALC_SRC = 4'd6,
        S_WB_EZ    = 4'd7,
        S_NEXT     = 4'd8,
        S_DONE     = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0]  WD_ALL        = '1;
    localparam logic [STEP_CNT_WIDTH-1:0] DEFAULT_LIMIT = STEP_CNT_WIDTH'(TIME_STEPS);
    // Strobe bit gi fires on entry to the state in nibble gi.
    localparam logic [19:0] STROBE_STATES = {S_CALC_SRC, S_CALC_EZ, S_CALC_HY, S_LD_EZ, S_LD_HY};

    state_t                    state_reg, state_next;
    logic [TIMEOUT_WIDTH-1:0]  wd_reg, wd_next, wd_inc;
    logic [STEP_CNT_WIDTH-1:0] step_reg, step_next, step_inc;
    logic [STEP_CNT_WIDTH-1:0] limit_reg, limit_next;
    logic                      timeout_reg, timeout_next;
    logic                      done_reg, done_next;
    logic                      busy_reg, busy_next;
    logic [4:0]                strobe_reg, strobe_next;
    logic                      exit_hit, in_wait, entering;

    assign wd_inc   = wd_reg + 1'b1;
    assign step_inc = step_reg + 1'b1;

    always_comb begin
        exit_hit = 1'b0;
        in_wait  = 1'b1;
        case (state_reg)
            S_LD_HY, S_LD_EZ: exit_hit = bus.buffer_done;
            S_CALC_HY:        exit_hit = bus.wrt_hy_start;
            S_WB_HY, S_WB_EZ: exit_hit = bus.mem_rd_end;
            S_CALC_EZ:        exit_hit = bus.wrt_ez_start;
            S_CALC_SRC:       exit_hit = bus.wrt_src_start;
            default:          in_wait  = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        limit_next   = limit_reg;
        step_next    = step_reg;
        timeout_next = timeout_reg;
        if (bus.abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_next   = S_LD_HY;
                        limit_next   = (bus.num_steps == '0) ? DEFAULT_LIMIT : bus.num_steps;
                        step_next    = '0;
                        timeout_next = 1'b0;
                    end
                end
                S_NEXT: begin
                    step_next  = step_inc;
                    state_next = (step_inc == limit_reg) ? S_DONE : S_LD_HY;
                end
                default: begin
                    if (exit_hit) begin
                        case (state_reg)
                            S_LD_HY:    state_next = S_LD_EZ;
                            S_LD_EZ:    state_next = S_CALC_HY;
                            S_CALC_HY:  state_next = S_WB_HY;
                            S_WB_HY:    state_next = S_CALC_EZ;
                            S_CALC_EZ:  state_next = S_CALC_SRC;
                            S_CALC_SRC: state_next = S_WB_EZ;
                            S_WB_EZ:    state_next = S_NEXT;
                            default:    state_next = state_reg;
                        endcase
                    end else if (wd_inc == WD_ALL) begin
                        state_next   = S_ERR;
                        timeout_next = 1'b1;
                    end
                end
            endcase
        end
        entering  = (state_next != state_reg);
        wd_next   = (entering || !in_wait) ? '0 : wd_inc;
        done_next = entering && (state_next == S_DONE);
        busy_next = !((state_next == S_IDLE) || (state_next == S_DONE) || (state_next == S_ERR));
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_strobe
        assign strobe_next[gi] = (state_next == state_t'(STROBE_STATES[gi*4 +: 4])) &&
                                 (state_reg != state_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            wd_reg      <= '0;
            step_reg    <= '0;
            limit_reg   <= '0;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            strobe_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            wd_reg      <= wd_next;
            step_reg    <= step_next;
            limit_reg   <= limit_next;
            timeout_reg <= timeout_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
            strobe_reg  <= strobe_next;
        end
    end

    assign bus.buffer_hy_start = strobe_reg[0];
    assign bus.buffer_ez_start = strobe_reg[1];
    assign bus.calc_hy_flg     = strobe_reg[2];
    assign bus.calc_ez_flg     = strobe_reg[3];
    assign bus.calc_src_flg    = strobe_reg[4];
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
    assign bus.timeout         = timeout_reg;
    assign bus.step_cnt        = step_reg;
    assign bus.state           = state_reg;
endmodule

// File: tb/tb_fdtd_step_sched.sv
// Directed bench for fdtd_step_sched: a responder returns completion pulses a fixed
// delay after each phase entry; table runs plus hand sequences for abort/timeout/reset.
module tb_fdtd_step_sched;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fdtd_step_sched_if #(.STEP_CNT_WIDTH(W)) bus ();

    fdtd_step_sched #(
        .TIME_STEPS    (50),
        .STEP_CNT_WIDTH(W),
        .TIMEOUT_WIDTH (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int num;
        int delay;
        int exp_steps;
        int exp_done_cyc;
    } vec_t;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int cyc, prev_state, in_cnt;
    int resp_delay, withhold, abort_state, abort_step;
    bit inject_stray, abort_with_start, stray_pending, timed_out;
    int strobe_cnt, order_err, done_cnt, done_cyc, first_strobe_cyc, ld_ez_cycles;

    task automatic check(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus.calc_src_flg, bus.calc_ez_flg, bus.calc_hy_flg,
                bus.buffer_ez_start, bus.buffer_hy_start};
    endfunction

    task automatic observe();
        logic [4:0] s;
        s = strobes();
        if ($countones(s) > 1) order_err++;
        for (int k = 0; k < 5; k++) begin
            if (s[k]) begin
                if (k != strobe_cnt % 5) order_err++;
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                strobe_cnt++;
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.state == 4'd2) ld_ez_cycles++;
        if (stray_pending) begin
            check("stray_hold_state", bus.state, 3);
            stray_pending = 1'b0;
        end
    endtask

    task automatic respond();
        int st;
        st = int'(bus.state);
        if (st == prev_state) in_cnt++;
        else in_cnt = 0;
        prev_state = st;
        bus.buffer_done   = 1'b0;
        bus.wrt_hy_start  = 1'b0;
        bus.wrt_ez_start  = 1'b0;
        bus.wrt_src_start = 1'b0;
        bus.mem_rd_end    = 1'b0;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        if (st >= 1 && st <= 7 && st != withhold && in_cnt == resp_delay) begin
            case (st)
                1, 2:    bus.buffer_done   = 1'b1;
                3:       bus.wrt_hy_start  = 1'b1;
                4, 7:    bus.mem_rd_end    = 1'b1;
                5:       bus.wrt_ez_start  = 1'b1;
                default: bus.wrt_src_start = 1'b1;
            endcase
        end
        if (inject_stray && st == 3 && in_cnt == 0) begin
            bus.wrt_ez_start = 1'b1;
            bus.start        = 1'b1;
            stray_pending    = 1'b1;
        end
        if (st == abort_state && int'(bus.step_cnt) == abort_step && in_cnt == 0) begin
            bus.abort = 1'b1;
            if (abort_with_start) bus.start = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        observe();
        respond();
    endtask

    task automatic clear_stats();
        cyc = 0;
        strobe_cnt = 0;
        order_err = 0;
        done_cnt = 0;
        done_cyc = -1;
        first_strobe_cyc = -1;
        ld_ez_cycles = 0;
    endtask

    // Starts a run and steps until the scheduler settles in IDLE, DONE or ERR.
    task automatic run(input int num, input int delay, input int budget);
        clear_stats();
        resp_delay    = delay;
        bus.num_steps = W'(num);
        bus.start     = 1'b1;
        timed_out     = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (bus.state == 4'd9 || bus.state == 4'd10 || bus.state == 4'd0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("run_budget", timed_out, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl[4];
        tbl[0] = '{num: 0, delay: 3, exp_steps: 50, exp_done_cyc: 1451};
        tbl[1] = '{num: 2, delay: 0, exp_steps: 2,  exp_done_cyc: 17};
        tbl[2] = '{num: 1, delay: 1, exp_steps: 1,  exp_done_cyc: 16};
        tbl[3] = '{num: 4, delay: 2, exp_steps: 4,  exp_done_cyc: 89};

        bus.start = 1'b0; bus.abort = 1'b0; bus.num_steps = '0;
        bus.buffer_done = 1'b0; bus.wrt_hy_start = 1'b0; bus.wrt_ez_start = 1'b0;
        bus.wrt_src_start = 1'b0; bus.mem_rd_end = 1'b0;
        prev_state = 0; in_cnt = 0; withhold = -1; abort_state = -1; abort_step = -1;
        inject_stray = 1'b0; abort_with_start = 1'b0; stray_pending = 1'b0;
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", bus.state, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_timeout", bus.timeout, 0);
        check("reset_step_cnt", bus.step_cnt, 0);
        check("reset_strobes", strobes(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i].num, tbl[i].delay, 2000);
            $display("vector %0d: num_steps=%0d delay=%0d step_cnt=%0d done_cycle=%0d strobes=%0d",
                     i, tbl[i].num, tbl[i].delay, bus.step_cnt, done_cyc, strobe_cnt);
            check("tbl_state_done", bus.state, 9);
            check("tbl_done_pulses", done_cnt, 1);
            check("tbl_done_cycle", done_cyc, tbl[i].exp_done_cyc);
            check("tbl_step_cnt", bus.step_cnt, tbl[i].exp_steps);
            check("tbl_busy", bus.busy, 0);
            check("tbl_strobe_cnt", strobe_cnt, 5 * tbl[i].exp_steps);
            check("tbl_strobe_order", order_err, 0);
            check("tbl_first_strobe", first_strobe_cyc, 1);
            cycle();
            check("tbl_done_one_cycle", bus.done, 0);
            check("tbl_done_hold", bus.state, 9);
        end

        // Stray wrt_Ez pulse and second start during CALC_HY.
        inject_stray = 1'b1;
        run(3, 2, 500);
        inject_stray = 1'b0;
        $display("stray: step_cnt=%0d done_cycle=%0d", bus.step_cnt, done_cyc);
        check("stray_state", bus.state, 9);
        check("stray_done_cycle", done_cyc, 67);
        check("stray_step_cnt", bus.step_cnt, 3);
        check("stray_done_pulses", done_cnt, 1);
        check("stray_order", order_err, 0);

        // Watchdog: buffer_done withheld in LD_EZ.
        withhold = 2;
        run(3, 1, 500);
        withhold = -1;
        $display("timeout: state=%0d ld_ez_cycles=%0d timeout=%0d", bus.state, ld_ez_cycles, bus.timeout);
        check("wd_state_err", bus.state, 10);
        check("wd_timeout", bus.timeout, 1);
        check("wd_busy", bus.busy, 0);
        check("wd_ld_ez_cycles", ld_ez_cycles, 15);
        check("wd_no_done", done_cnt, 0);
        cycle();
        check("wd_timeout_sticky", bus.timeout, 1);
        bus.num_steps = W'(1);
        bus.start = 1'b1;
        cycle();
        $display("restart after timeout: state=%0d timeout=%0d", bus.state, bus.timeout);
        check("wd_restart_state", bus.state, 1);
        check("wd_restart_clear", bus.timeout, 0);
        check("wd_restart_strobe", bus.buffer_hy_start, 1);
        bus.abort = 1'b1;
        cycle();
        check("wd_abort_idle", bus.state, 0);

        // Abort in CALC_SRC of step 1, coinciding with its exit pulse.
        abort_state = 6; abort_step = 1;
        run(3, 0, 500);
        abort_state = -1; abort_step = -1;
        $display("abort: state=%0d step_cnt=%0d strobes=%0d", bus.state, bus.step_cnt, strobe_cnt);
        check("abort_state", bus.state, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_step_cnt", bus.step_cnt, 1);
        check("abort_strobes", strobe_cnt, 10);
        repeat (2) cycle();
        check("abort_no_more_strobes", strobe_cnt, 10);
        check("abort_no_done", done_cnt, 0);
        check("abort_stay_idle", bus.state, 0);

        // Abort together with start while busy, then again while idle.
        abort_state = 2; abort_step = 0; abort_with_start = 1'b1;
        run(5, 1, 100);
        abort_state = -1; abort_step = -1; abort_with_start = 1'b0;
        $display("abort+start busy: state=%0d strobes=%0d", bus.state, strobe_cnt);
        check("abst_busy_state", bus.state, 0);
        check("abst_busy_busy", bus.busy, 0);
        check("abst_busy_strobes", strobe_cnt, 2);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        cycle();
        $display("abort+start idle: state=%0d", bus.state);
        check("abst_idle_state", bus.state, 0);
        check("abst_idle_strobes", strobe_cnt, 2);

        // Asynchronous reset in the middle of WB_HY.
        clear_stats();
        resp_delay = 2;
        bus.num_steps = W'(3);
        bus.start = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (bus.state == 4'd4) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("rst_reach_wb_hy", timed_out, 0);
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset: state=%0d busy=%0d strobes=%0d", bus.state, bus.busy, strobes());
        check("rst_state", bus.state, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_step_cnt", bus.step_cnt, 0);
        check("rst_strobes", strobes(), 0);
        check("rst_done", bus.done, 0);
        check("rst_timeout", bus.timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_state = 0;
        in_cnt = 0;
        run(1, 0, 100);
        $display("post-reset run: step_cnt=%0d done_cycle=%0d", bus.step_cnt, done_cyc);
        check("rst_rerun_state", bus.state, 9);
        check("rst_rerun_done_cycle", done_cyc, 9);
        check("rst_rerun_step_cnt", bus.step_cnt, 1);
        check("rst_rerun_order", order_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
